// File: rtl/rs_frame_ctrl_pkg.sv
// Shared encodings for the Reed-Solomon frame sequencer: main/sender FSM states
// and counter width.
package rs_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_MSG   = 3'd2,
    ST_PAR   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } main_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_GUARD = 2'd2,
    S_WAIT  = 2'd3
  } send_state_t;

endpackage

// File: rtl/rs_frame_ctrl_if.sv
// Byte/encoder/transmitter signal bundle around rs_frame_ctrl.
// master = the frame controller, slave = the surrounding UART/encoder logic.
interface rs_frame_ctrl_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       enc_clear;
  logic       enc_ce;
  logic [7:0] enc_data;
  logic       enc_parity_shift;
  logic [7:0] enc_parity;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  modport master (
    input  in_valid, in_byte, enc_parity, tx_busy,
    output enc_clear, enc_ce, enc_data, enc_parity_shift,
           tx_start, tx_data, busy, frame_done, overrun
  );

  modport slave (
    output in_valid, in_byte, enc_parity, tx_busy,
    input  enc_clear, enc_ce, enc_data, enc_parity_shift,
           tx_start, tx_data, busy, frame_done, overrun
  );
endinterface

// File: rtl/rs_frame_ctrl_sender.sv
// Byte sender: takes one byte per load, pulses tx_start and holds tx_data until
// the transmitter drops tx_busy.
module tx_byte_sender
  import rs_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_tx_busy,
  output logic       o_ready,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data
);

  send_state_t r_state;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;

  // Ready in WAIT as soon as busy drops, so a queued byte starts without an idle cycle.
  assign o_ready    = (r_state == S_IDLE) || ((r_state == S_WAIT) && !i_tx_busy);
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE, S_WAIT: begin
          if (o_ready) begin
            if (i_load) begin
              r_tx_data  <= i_data;
              r_tx_start <= 1'b1;
              r_state    <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_START: r_state <= S_GUARD;
        S_GUARD: r_state <= S_WAIT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rs_frame_ctrl.sv
// Frame sequencer: forwards MSG_LEN message bytes to encoder and transmitter,
// then drains PAR_LEN parity bytes and clears the encoder.
module rs_frame_ctrl
  import rs_ctrl_pkg::*;
#(
  parameter int MSG_LEN = 8,
  parameter int PAR_LEN = 4
) (
  input logic           clk,
  input logic           reset,
  rs_frame_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_LEN);
  localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(PAR_LEN);

  main_state_t      r_state;
  logic [CNT_W-1:0] r_msg_cnt;
  logic [CNT_W-1:0] r_par_cnt;
  logic [7:0]       r_pend;
  logic             r_pend_full;

  logic             w_open;
  logic             w_accept;
  logic             w_shift;
  logic             w_load;
  logic             w_sender_ready;
  logic [CNT_W-1:0] w_msg_next;
  logic [CNT_W-1:0] w_par_next;

  assign w_open     = (r_state == ST_IDLE) || (r_state == ST_MSG);
  assign w_accept   = bus.in_valid && w_open && !r_pend_full && !reset;
  assign w_shift    = (r_state == ST_PAR) && !r_pend_full;
  assign w_load     = r_pend_full && w_sender_ready;
  assign w_msg_next = r_msg_cnt + 8'd1;
  assign w_par_next = r_par_cnt + 8'd1;

  // INIT clear is gated by reset so every output reads 0 while reset is held.
  assign bus.enc_clear        = ((r_state == ST_INIT) && !reset) || (r_state == ST_DONE);
  assign bus.enc_ce           = w_accept;
  assign bus.enc_data         = w_accept ? bus.in_byte : 8'h00;
  assign bus.enc_parity_shift = w_shift;
  assign bus.overrun          = bus.in_valid && !w_accept && !reset;
  assign bus.frame_done       = (r_state == ST_DONE);
  assign bus.busy             = (r_state != ST_INIT) && (r_state != ST_IDLE);

  tx_byte_sender u_sender (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_data    (r_pend),
    .i_tx_busy (bus.tx_busy),
    .o_ready   (w_sender_ready),
    .o_tx_start(bus.tx_start),
    .o_tx_data (bus.tx_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_msg_cnt   <= '0;
      r_par_cnt   <= '0;
      r_pend      <= 8'h00;
      r_pend_full <= 1'b0;
    end else begin
      // load, accept and shift are mutually exclusive on pend_full
      if (w_load) r_pend_full <= 1'b0;
      if (w_accept) begin
        r_pend      <= bus.in_byte;
        r_pend_full <= 1'b1;
        r_msg_cnt   <= w_msg_next;
      end
      if (w_shift) begin
        r_pend      <= bus.enc_parity;
        r_pend_full <= 1'b1;
        r_par_cnt   <= w_par_next;
      end
      case (r_state)
        ST_INIT: r_state <= ST_IDLE;
        ST_IDLE, ST_MSG: begin
          if (w_accept) r_state <= (w_msg_next == MSG_LAST) ? ST_PAR : ST_MSG;
        end
        ST_PAR: begin
          if (w_shift && (w_par_next == PAR_LAST)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!r_pend_full && w_sender_ready) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_msg_cnt <= '0;
          r_par_cnt <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_frame_ctrl.sv
// Self-checking bench for rs_frame_ctrl (MSG_LEN=4, PAR_LEN=2) with simple
// transmitter and encoder models.
module tb_rs_frame_ctrl;

  typedef struct {
    logic [7:0] data;
    int         gap;
    logic       exp_ce;
    logic       exp_ovr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rs_frame_ctrl_if bus();

  rs_frame_ctrl #(.MSG_LEN(4), .PAR_LEN(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Encoder model: parity table index advances on shift, restarts on clear.
  logic [7:0] par_tab [0:3];
  int         par_idx = 0;
  always @(posedge clk) begin
    if (bus.enc_clear) par_idx <= 0;
    else if (bus.enc_parity_shift) par_idx <= par_idx + 1;
  end
  assign bus.enc_parity = par_tab[par_idx[1:0]];

  // Transmitter model and event monitor, sampled on the falling edge.
  int         busy_len = 10;
  int         busy_cnt = 0;
  int         cyc = 0;
  int         ce_n = 0, sh_n = 0, fd_n = 0, clr_n = 0, cd_n = 0, ovr_n = 0, tx_n = 0, derr_n = 0;
  logic [7:0] tx_log [0:63];
  int         tx_cyc [0:63];
  assign bus.tx_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    cyc++;
    if (bus.tx_start) begin
      if (tx_n < 64) begin
        tx_log[tx_n] = bus.tx_data;
        tx_cyc[tx_n] = cyc;
      end
      tx_n++;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (bus.enc_ce) ce_n++;
    if (bus.enc_parity_shift) sh_n++;
    if (bus.frame_done) fd_n++;
    if (bus.enc_clear) clr_n++;
    if (bus.enc_clear && bus.frame_done) cd_n++;
    if (bus.overrun) ovr_n++;
    if (bus.enc_ce && (bus.enc_data != bus.in_byte)) derr_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b, output logic ce, output logic ovr, output logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(negedge clk);
    ce  = bus.enc_ce;
    ovr = bus.overrun;
    d   = bus.enc_data;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_tx(input string name, input int base, input logic [7:0] exp_q[$]);
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s_byte%0d", name, k), int'(tx_log[(base + k) & 63]), int'(exp_q[k]));
  endtask

  initial begin
    vec_t       tbl [5];
    logic       ce, ovr;
    logic [7:0] d;
    logic [7:0] exp_q[$];
    int ce0, sh0, fd0, clr0, cd0, ovr0, tx0, derr0;
    int k, n_acc, tries, min_gap;

    par_tab[0] = 8'hA5; par_tab[1] = 8'h5A; par_tab[2] = 8'hC3; par_tab[3] = 8'h3C;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // ---- reset: all outputs low for 3 held cycles, then one INIT clear
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_outputs_c%0d", i),
            int'({bus.enc_clear, bus.enc_ce, bus.enc_data, bus.enc_parity_shift,
                  bus.tx_start, bus.tx_data, bus.busy, bus.frame_done, bus.overrun}), 0);
    end
    clr0  = clr_n;
    reset = 1'b0;
    @(negedge clk);
    check("init_clear", int'(bus.enc_clear), 1);
    check("init_busy", int'(bus.busy), 0);
    repeat (4) tick();
    check("init_clear_count", clr_n - clr0, 1);

    // ---- full frame from the vector table, plus drops in PAR and DRAIN
    tbl[0] = '{8'h11, 20, 1'b1, 1'b0};
    tbl[1] = '{8'h22, 20, 1'b1, 1'b0};
    tbl[2] = '{8'h33, 20, 1'b1, 1'b0};
    tbl[3] = '{8'h44,  1, 1'b1, 1'b0};
    tbl[4] = '{8'h77,  0, 1'b0, 1'b1};
    busy_len = 10;
    ce0 = ce_n; sh0 = sh_n; fd0 = fd_n; clr0 = clr_n; cd0 = cd_n; ovr0 = ovr_n; tx0 = tx_n; derr0 = derr_n;
    for (int i = 0; i < 5; i++) begin
      strobe(tbl[i].data, ce, ovr, d);
      check($sformatf("vec%0d_enc_ce", i), int'(ce), int'(tbl[i].exp_ce));
      check($sformatf("vec%0d_overrun", i), int'(ovr), int'(tbl[i].exp_ovr));
      if (tbl[i].exp_ce) check($sformatf("vec%0d_enc_data", i), int'(d), int'(tbl[i].data));
      repeat (tbl[i].gap) tick();
    end
    k = 0;
    while ((sh_n - sh0) < 2 && k < 300) begin tick(); k++; end
    check("full_two_shifts", sh_n - sh0, 2);
    strobe(8'h88, ce, ovr, d);
    check("drain_overrun", int'(ovr), 1);
    check("drain_no_ce", int'(ce), 0);
    k = 0;
    while ((fd_n - fd0) < 1 && k < 300) begin tick(); k++; end
    repeat (5) tick();
    check("full_tx_count", tx_n - tx0, 6);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A};
    check_tx("full_tx", tx0, exp_q);
    check("full_enc_ce", ce_n - ce0, 4);
    check("full_frame_done", fd_n - fd0, 1);
    check("full_enc_clear", clr_n - clr0, 1);
    check("full_clear_with_done", cd_n - cd0, 1);
    check("full_overruns", ovr_n - ovr0, 2);
    check("full_enc_data", derr_n - derr0, 0);

    // ---- reset with one byte in flight and one pending
    busy_len = 100;
    strobe(8'hC1, ce, ovr, d);
    check("rst_c1_ce", int'(ce), 1);
    repeat (4) tick();
    strobe(8'hC2, ce, ovr, d);
    check("rst_c2_ce", int'(ce), 1);
    repeat (2) tick();
    tx0 = tx_n; clr0 = clr_n;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_reinit_clear", int'(bus.enc_clear), 1);
    check("rst_busy_low", int'(bus.busy), 0);
    repeat (150) tick();
    check("rst_no_old_tx", tx_n - tx0, 0);
    check("rst_clear_count", clr_n - clr0, 1);

    // ---- overrun while the transmitter is held busy
    busy_len = 100;
    ce0 = ce_n; fd0 = fd_n; tx0 = tx_n;
    strobe(8'hD1, ce, ovr, d);
    check("ovr_d1_ce", int'(ce), 1);
    repeat (4) tick();
    strobe(8'hD2, ce, ovr, d);
    check("ovr_d2_ce", int'(ce), 1);
    repeat (4) tick();
    strobe(8'hD3, ce, ovr, d);
    check("ovr_d3_overrun", int'(ovr), 1);
    check("ovr_d3_no_ce", int'(ce), 0);
    k = 0;
    while ((tx_n - tx0) < 2 && k < 400) begin tick(); k++; end
    k = 0;
    while (bus.tx_busy && k < 200) begin tick(); k++; end
    repeat (20) tick();
    check("ovr_tx_count", tx_n - tx0, 2);
    busy_len = 10;
    strobe(8'hD4, ce, ovr, d);
    repeat (20) tick();
    strobe(8'hD5, ce, ovr, d);
    k = 0;
    while ((fd_n - fd0) < 1 && k < 300) begin tick(); k++; end
    repeat (5) tick();
    exp_q = '{8'hD1, 8'hD2, 8'hD4, 8'hD5, 8'hA5, 8'h5A};
    check("ovr_frame_tx_count", tx_n - tx0, 6);
    check_tx("ovr_tx", tx0, exp_q);
    check("ovr_enc_ce", ce_n - ce0, 4);
    check("ovr_frame_done", fd_n - fd0, 1);

    // ---- back-to-back frames, transmitter never busy
    busy_len = 0;
    k = 0;
    while (bus.tx_busy && k < 200) begin tick(); k++; end
    fd0 = fd_n; tx0 = tx_n; n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      tries = 0;
      ce = 1'b0;
      while (!ce && tries < 30) begin
        strobe(8'h10 + 8'(i), ce, ovr, d);
        repeat (2) tick();
        tries++;
      end
      if (ce) n_acc++;
    end
    k = 0;
    while ((fd_n - fd0) < 2 && k < 300) begin tick(); k++; end
    repeat (5) tick();
    check("b2b_accepted", n_acc, 8);
    check("b2b_tx_count", tx_n - tx0, 12);
    check("b2b_frame_done", fd_n - fd0, 2);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hA5, 8'h5A,
              8'h14, 8'h15, 8'h16, 8'h17, 8'hA5, 8'h5A};
    check_tx("b2b_tx", tx0, exp_q);
    min_gap = 1000;
    for (int j = 1; j < 12; j++) begin
      if (tx_cyc[(tx0 + j) & 63] - tx_cyc[(tx0 + j - 1) & 63] < min_gap)
        min_gap = tx_cyc[(tx0 + j) & 63] - tx_cyc[(tx0 + j - 1) & 63];
    end
    check("b2b_min_tx_spacing", min_gap, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_frame_ctrl.md
# rs_frame_ctrl

Frame sequencer for the Reed-Solomon encode path. It sits between the UART receive byte FSM and the UART transmitter, with the RS encoder LFSR alongside. It groups incoming message bytes into frames of MSG_LEN bytes and feeds each byte to the encoder while forwarding it to the transmitter. After the last message byte it drains PAR_LEN parity bytes from the encoder into the transmit stream, then clears the encoder for the next frame.

## Interface
- MSG_LEN, default 8: message bytes per frame; legal range 1..254.
- PAR_LEN, default 4: parity bytes per frame; legal range 1..254, and MSG_LEN+PAR_LEN ≤ 255.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  single-cycle strobe, in_byte valid.
- in_byte  in  8  received message byte.
- enc_clear  out  1  one-cycle pulse; encoder clears its parity register.
- enc_ce  out  1  one-cycle pulse; encoder absorbs enc_data.
- enc_data  out  8  byte to encoder; equals in_byte while enc_ce is high.
- enc_parity_shift  out  1  one-cycle pulse; encoder shifts its parity register by one byte.
- enc_parity  in  8  current head parity byte; valid combinationally in the cycle enc_parity_shift is high (pre-shift value).
- tx_start  out  1  one-cycle pulse; transmitter starts sending tx_data.
- tx_data  out  8  registered byte; held stable until the next tx_start.
- tx_busy  in  1  transmitter busy; rises no later than 1 cycle after tx_start.
- busy  out  1  high while a frame is in progress (state not IDLE/INIT).
- frame_done  out  1  one-cycle pulse when the last parity byte has left the transmitter.
- overrun  out  1  one-cycle pulse; the in_valid byte in that cycle was dropped.

## Operation
- Main FSM states:
  - INIT: entered from reset. Asserts enc_clear for 1 cycle, then goes to IDLE.
  - IDLE: on an accepted byte, goes to MSG with msg_cnt=1. If MSG_LEN==1, goes straight to PAR.
  - MSG: each accepted byte does msg_cnt+1. When msg_cnt reaches MSG_LEN, goes to PAR.
  - PAR: whenever pend_full==0, pulses enc_parity_shift, loads pend←enc_parity and sets par_cnt+1. After the PAR_LEN-th shift, goes to DRAIN.
  - DRAIN: waits until pend_full==0 and the sender is idle, then goes to DONE.
  - DONE: asserts frame_done and enc_clear for 1 cycle, clears msg_cnt and par_cnt, then goes to IDLE.
- Accept rule: a byte is accepted when in_valid && state∈{IDLE,MSG} && !pend_full.
  - Same cycle: enc_ce=1, enc_data=in_byte.
  - Next edge: pend←in_byte, pend_full←1.
- Drop rule: in_valid when not accepted (pend_full, or state PAR/DRAIN/DONE/INIT) produces an overrun pulse in the same cycle. The byte is dropped: no enc_ce, no count change.
- Pending register pend (8 bits) plus the sender's tx_data register give 2 bytes of elasticity.
- Sender FSM states:
  - S_IDLE: if pend_full, tx_data←pend, pend_full←0, then goes to S_START.
  - S_START: tx_start=1.
  - S_GUARD: ignores tx_busy for one cycle.
  - S_WAIT: stays until tx_busy==0, then goes to S_IDLE.
- Transmit byte order is exactly: message bytes in arrival order, then parity bytes in shift order.
- Counters are 8 bits. Compare with ==, not ≥; counters never wrap within a legal configuration.
- Reset mid-frame: the frame is abandoned. pend_full, counters and sender return to idle, and no tx_start is issued for abandoned bytes. The first cycle after reset release is INIT, which re-clears the encoder. A transmitter byte already in flight is not aborted by this block.

## Timing
- Reset values: all outputs 0 (tx_data=0x00); main FSM=INIT, sender=S_IDLE.
- Byte accepted in cycle t:
  - enc_ce in t.
  - pend_full high in t+1.
  - tx_start in t+2 if the sender was idle at t+1.
- Minimum tx_start spacing: 3 cycles (START, GUARD, WAIT with tx_busy low).
- PAR: enc_parity_shift in cycle p implies pend_full high at p+1. The next shift can occur no earlier than p+2 (the cycle after the sender takes pend).
- frame_done arrives 1 cycle after DRAIN sees the sender idle, i.e. at least 1 cycle after tx_busy falls for the last parity byte.
- An accepted in_valid in the same cycle as DONE is impossible: the byte is dropped with overrun.

## Structure
- Package rs_ctrl_pkg holds:
  - main state encodings ST_INIT, ST_IDLE, ST_MSG, ST_PAR, ST_DRAIN, ST_DONE (3 bits);
  - sender encodings S_IDLE, S_START, S_GUARD, S_WAIT (2 bits);
  - counter width constant CNT_W=8.
- One sub-module, tx_byte_sender: the sender FSM plus the tx_data register, with a load/ready handshake to the main FSM. Pend register and counters stay in the top.

## Test plan
- Reset: hold reset 3 cycles → all outputs 0. After release: enc_clear=1 exactly 1 cycle, busy=0.
- Full frame (MSG_LEN=4, PAR_LEN=2):
  - Stimulus: bytes 11,22,33,44 spaced 20 cycles; tx model busy 10 cycles; encoder model returns A5 then 5A.
  - Required: tx sequence 11,22,33,44,A5,5A; 4 enc_ce; 2 enc_parity_shift; 1 frame_done; enc_clear coincides with frame_done.
- Overrun: tx model holds tx_busy high 100 cycles; send 3 bytes 5 cycles apart → third byte gives overrun, no enc_ce, and only 2 bytes are transmitted once busy drops.
- in_valid during PAR/DRAIN → overrun pulse; the frame still completes with the correct parity.
- Reset after 2 of 4 message bytes → no further tx_start from the old frame; enc_clear after release; the next frame's 4 bytes produce exactly one frame_done.
- Transmitter that never raises tx_busy, and back-to-back frames → no hang; tx_start spacing 3 cycles; 2 frame_done pulses for 12 transmitted bytes.
